// File: rtl/dac_feeder_pkg.sv
// Shared types and constants for the DAC sample feeder.
package dac_feeder_pkg;

    localparam int DAC_DATA_W   = 12;
    localparam int UNDERRUN_W   = 8;
    localparam int UNDERRUN_MAX = 255;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE
    } feeder_state_e;

    // Increment that sticks at UNDERRUN_MAX instead of wrapping.
    function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] value);
        return (value == UNDERRUN_W'(UNDERRUN_MAX)) ? value : value + UNDERRUN_W'(1);
    endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous sample FIFO with flush, full/empty/level and a sticky overflow flag.
// The read port is a pop: the head sample is registered into rd_data and held
// there until the next pop.
module dac_sample_fifo
    import dac_feeder_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [DAC_DATA_W-1:0]  wr_data,
    input  logic                   rd_en,
    output logic [DAC_DATA_W-1:0]  rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DAC_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign full  = (level == (AW + 1)'(DEPTH));
    assign empty = (level == '0);
    // Flush wins over a same-cycle write; a write while full is dropped.
    assign do_wr = wr_en && !full && !flush;
    assign do_rd = rd_en && !empty;

    // Sample storage.
    // NOTE: the array has no reset; pointers and level alone define which
    // entries are valid, so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: ;
            endcase
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    // Registered read port: holds the last popped sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (do_rd) begin
            rd_data <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// Paces buffered 12-bit samples into one DAC controller channel: one
// conversion per sample-rate tick, handshaken with cnv_start / cnv_done.
// Optional: define DAC_FEEDER_TIMEOUT_EN to abandon a conversion after
// TIMEOUT_CYCLES cycles without cnv_done and flag timeout_err.
module dac_sample_feeder
    import dac_feeder_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [15:0]            period,
    input  logic                   wr_en,
    input  logic [DAC_DATA_W-1:0]  wr_data,
    input  logic                   cnv_done,
    output logic [DAC_DATA_W-1:0]  dac_data,
    output logic                   cnv_start,
    output logic                   busy,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [UNDERRUN_W-1:0]  underrun_cnt,
    output logic                   overflow,
    output logic                   timeout_err
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    feeder_state_e state;
    feeder_state_e next_state;

    logic [15:0] count;
    logic [15:0] period_r;
    logic [15:0] cur_period;
    logic        tick;
    logic        pending;
    logic        go;
    logic        pop;
    logic        underrun_hit;

    // ---------------- sample-rate timer ----------------
    // The live period is only sampled while the count sits at 0, so a new
    // period value takes effect at the next wrap.
    assign cur_period = (count == '0) ? period : period_r;
    assign tick       = enable && ((cur_period == '0) || (count == cur_period - 16'd1));

    // Timer count and the period captured for the current interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            period_r <= '0;
        end else begin
            period_r <= cur_period;
            if (!enable || tick) begin
                count <= '0;
            end else begin
                count <= count + 16'd1;
            end
        end
    end

    // A tick is acted on in the same cycle when the FSM is idle; otherwise it
    // is remembered once in pending and any further ticks are dropped.
    assign go           = (state == IDLE) && enable && (pending || tick);
    assign underrun_hit = go && fifo_empty;

    // pending flag: consumed whenever an idle FSM acts on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (go) begin
            pending <= 1'b0;
        end else if (tick) begin
            pending <= 1'b1;
        end
    end

    // Saturating underrun counter; flush clears it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            underrun_cnt <= '0;
        end else if (underrun_hit) begin
            underrun_cnt <= sat_inc(underrun_cnt);
        end
    end

    // ---------------- optional cnv_done timeout ----------------
`ifdef DAC_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;
    logic          timeout_hit;

    assign timeout_hit = (state == WAIT_DONE) && !cnv_done &&
                         (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Cycles spent in WAIT_DONE for the current conversion.
    always_ff @(posedge clk) begin
        if (rst || state != WAIT_DONE) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + TW'(1);
        end
    end

    // Sticky timeout flag; flush clears it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    // ---------------- conversion FSM ----------------
    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The FIFO pop is issued on the IDLE->LOAD transition so
    // the sample sits in the read register throughout LOAD, one full cycle
    // ahead of cnv_start.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (go && !fifo_empty) begin
                    next_state = LOAD;
                    pop        = 1'b1;
                end
            end
            LOAD:  next_state = START;
            START: next_state = WAIT_DONE;
            WAIT_DONE: begin
                if (cnv_done) begin
                    next_state = IDLE;
                end
`ifdef DAC_FEEDER_TIMEOUT_EN
                else if (timeout_hit) begin
                    next_state = IDLE;
                end
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    assign cnv_start = (state == START);
    assign busy      = (state != IDLE);

    dac_sample_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (dac_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level),
        .overflow(overflow)
    );

endmodule
